// File: rtl/ysyx_ifu.sv
// ysyx_ifu: instruction fetch unit.
// Holds the PC and keeps at most one instruction-memory request in flight.
// Delivers {inst, pc, err} to decode over a valid/ready handshake.
// A redirect from execute overrides the PC in every state. A response that
// belongs to a superseded fetch is dropped. A misaligned PC produces a
// faulting NOP slot instead of a memory request.
module ysyx_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            imem_rsp_err,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic            out_err
);

  localparam logic [31:0]     NOP_INST = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP  = XLEN'(32'd4);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [XLEN-1:0]   pc_r;
  logic [XLEN-1:0]   pc_nxt_s;
  logic              drop_r;
  logic              drop_nxt_s;
  logic              req_valid_r;
  logic              req_valid_nxt_s;
  logic              out_valid_r;
  logic              out_valid_nxt_s;
  logic [31:0]       out_inst_r;
  logic [31:0]       out_inst_nxt_s;
  logic [XLEN-1:0]   out_pc_r;
  logic [XLEN-1:0]   out_pc_nxt_s;
  logic              out_err_r;
  logic              out_err_nxt_s;
  logic              req_fire_s;
  logic              pc_misaligned_s;

  assign req_fire_s      = req_valid_r & imem_req_ready;
  assign pc_misaligned_s = (pc_r[1:0] != 2'b00);

  // Next-state, next-PC and next-output-slot decode for the fetch FSM.
  always_comb begin
    state_nxt_s     = state_r;
    pc_nxt_s        = pc_r;
    drop_nxt_s      = drop_r;
    out_valid_nxt_s = out_valid_r;
    out_inst_nxt_s  = out_inst_r;
    out_pc_nxt_s    = out_pc_r;
    out_err_nxt_s   = out_err_r;
    case (state_r)
      ST_REQ: begin
        if (redirect_valid) begin
          pc_nxt_s = redirect_pc;
          if (req_fire_s) begin
            // The old request is still accepted; its response must be dropped.
            drop_nxt_s  = 1'b1;
            state_nxt_s = ST_WAIT;
          end else begin
            state_nxt_s = ST_REQ;
          end
        end else if (pc_misaligned_s) begin
          // Never fetch from a misaligned PC: hand decode a faulting NOP.
          out_valid_nxt_s = 1'b1;
          out_inst_nxt_s  = NOP_INST;
          out_pc_nxt_s    = pc_r;
          out_err_nxt_s   = 1'b1;
          state_nxt_s     = ST_HOLD;
        end else if (req_fire_s) begin
          state_nxt_s = ST_WAIT;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (redirect_valid) begin
          pc_nxt_s = redirect_pc;
          if (imem_rsp_valid) begin
            // The response arriving now is discarded and nothing remains in
            // flight, so there is nothing left to drop.
            drop_nxt_s  = 1'b0;
            state_nxt_s = ST_REQ;
          end else begin
            drop_nxt_s  = 1'b1;
            state_nxt_s = ST_WAIT;
          end
        end else if (imem_rsp_valid) begin
          if (drop_r) begin
            drop_nxt_s  = 1'b0;
            state_nxt_s = ST_REQ;
          end else begin
            out_valid_nxt_s = 1'b1;
            out_inst_nxt_s  = imem_rsp_data;
            out_pc_nxt_s    = pc_r;
            out_err_nxt_s   = imem_rsp_err;
            state_nxt_s     = ST_HOLD;
          end
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (redirect_valid) begin
          // Redirect wins over the handshake: the held slot is discarded.
          pc_nxt_s        = redirect_pc;
          out_valid_nxt_s = 1'b0;
          state_nxt_s     = ST_REQ;
        end else if (out_ready) begin
          pc_nxt_s        = pc_r + PC_STEP;
          out_valid_nxt_s = 1'b0;
          state_nxt_s     = ST_REQ;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      default: begin
        out_valid_nxt_s = 1'b0;
        drop_nxt_s      = 1'b0;
        state_nxt_s     = ST_REQ;
      end
    endcase
    // A request is offered only from REQ with an aligned PC.
    if ((state_nxt_s == ST_REQ) && (pc_nxt_s[1:0] == 2'b00)) begin
      req_valid_nxt_s = 1'b1;
    end else begin
      req_valid_nxt_s = 1'b0;
    end
  end

  // State, PC and registered output slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_REQ;
      pc_r        <= XLEN'(RESET_PC);
      drop_r      <= 1'b0;
      req_valid_r <= 1'b0;
      out_valid_r <= 1'b0;
      out_inst_r  <= 32'h0000_0000;
      out_pc_r    <= '0;
      out_err_r   <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      pc_r        <= pc_nxt_s;
      drop_r      <= drop_nxt_s;
      req_valid_r <= req_valid_nxt_s;
      out_valid_r <= out_valid_nxt_s;
      out_inst_r  <= out_inst_nxt_s;
      out_pc_r    <= out_pc_nxt_s;
      out_err_r   <= out_err_nxt_s;
    end
  end

  assign imem_req_valid = req_valid_r;
  assign imem_req_addr  = pc_r;
  assign out_valid      = out_valid_r;
  assign out_inst       = out_inst_r;
  assign out_pc         = out_pc_r;
  assign out_err        = out_err_r;

endmodule
